// File: rtl/de1_soc_demo_key_pio.sv
// Avalon-MM pushbutton/switch input PIO: synchronizes and debounces pins, captures
// selected edges into a W1C register and raises a maskable level interrupt.
module de1_soc_demo_key_pio #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE       = 1,
    parameter int unsigned INVERT          = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0]            pin_logic_c;
    logic [WIDTH-1:0]            s1_q, s2_q;
    logic [WIDTH-1:0]            db_q, db_d;
    logic [WIDTH-1:0]            db_dly_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]            irqmask_q, irqmask_d;
    logic [WIDTH-1:0]            edgecap_q, edgecap_d;
    logic [WIDTH-1:0]            rise_c, fall_c, edge_c, clr_c;
    logic                        wr_en_c;
    logic                        unused_wdata;

    assign pin_logic_c  = (INVERT != 0) ? ~in_port : in_port;
    assign wr_en_c      = chipselect & ~write_n;
    assign unused_wdata = ^writedata[31:WIDTH];

    // State registers: synchronizer, debouncer, edge delay and CSRs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            db_dly_q  <= '0;
            cnt_q     <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            s1_q      <= pin_logic_c;
            s2_q      <= s1_q;
            db_q      <= db_d;
            db_dly_q  <= db_q;
            cnt_q     <= cnt_d;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    // Per-bit debounce: a new level is accepted only after DEBOUNCE_CYCLES differing samples.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edge selection on the debounced logical value.
    always_comb begin
        rise_c = db_q & ~db_dly_q;
        fall_c = ~db_q & db_dly_q;
        if (EDGE_TYPE == 0) begin
            edge_c = rise_c;
        end else if (EDGE_TYPE == 1) begin
            edge_c = fall_c;
        end else begin
            edge_c = rise_c | fall_c;
        end
    end

    // CSR writes; a fresh edge outranks a same-cycle W1C on its bit.
    always_comb begin
        irqmask_d = irqmask_q;
        clr_c     = '0;
        if (wr_en_c && (address == ADDR_IRQMASK)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en_c && (address == ADDR_EDGECAP)) begin
            clr_c = writedata[WIDTH-1:0];
        end
        edgecap_d = (edgecap_q & ~clr_c) | edge_c;
    end

    // Zero-wait-state read mux, side-effect free.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = 32'(db_q);
            ADDR_IRQMASK: readdata = 32'(irqmask_q);
            ADDR_EDGECAP: readdata = 32'(edgecap_q);
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_de1_soc_demo_key_pio.sv
// Bench for de1_soc_demo_key_pio: window-based behavioural model checked every cycle,
// plus directed KEY press/release scenarios with literal expectations.
module tb_de1_soc_demo_key_pio;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [3:0]  in_port = 4'hF;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    logic checking = 1'b0;

    de1_soc_demo_key_pio #(
        .WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1), .INVERT(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    // Model: hist[j] is the logical pin value sampled j clock edges ago.
    logic [3:0] hist [1:D+1];
    logic [3:0] m_db = '0, m_db_dly = '0, m_mask = '0, m_cap = '0;
    logic [3:0] m_nd, m_fall;
    logic       m_same;

    // The debounced level takes value v once the D samples seen by the debouncer all equal v.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 1; j <= D + 1; j++) hist[j] = '0;
            m_db = '0; m_db_dly = '0; m_mask = '0; m_cap = '0;
        end else begin
            m_nd = m_db;
            for (int b = 0; b < 4; b++) begin
                m_same = 1'b1;
                for (int j = 2; j <= D + 1; j++)
                    if (hist[j][b] != hist[2][b]) m_same = 1'b0;
                if (m_same && (hist[2][b] != m_db[b])) m_nd[b] = hist[2][b];
            end
            m_fall = ~m_db & m_db_dly;
            if (chipselect && !write_n && address == 2'd3) m_cap = m_cap & ~writedata[3:0];
            m_cap = m_cap | m_fall;
            if (chipselect && !write_n && address == 2'd1) m_mask = writedata[3:0];
            m_db_dly = m_db;
            m_db     = m_nd;
            for (int j = D + 1; j >= 2; j--) hist[j] = hist[j-1];
            hist[1] = ~in_port;
        end
    end

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_db};
            2'd1:    return {28'd0, m_mask};
            2'd3:    return {28'd0, m_cap};
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            check("cyc_irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
            check("cyc_readdata", readdata, m_read(address));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick(1);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic rd_check(input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a;
        #1;
        check(name, readdata, exp);
    endtask

    initial begin
        tick(3);
        reset_n = 1'b1;
        tick(2);
        checking = 1'b1;

        // Reset state with all keys released.
        rd_check(2'd0, 32'd0, "t1_data");
        rd_check(2'd3, 32'd0, "t1_edgecap");
        check("t1_irq", {31'd0, irq}, 32'd0);
        tick(1);
        rd_check(2'd1, 32'd0, "t1_mask");
        rd_check(2'd2, 32'd0, "t1_rsvd");

        // KEY0 press is a logical rise (not captured); its release is the captured fall.
        address = 2'd0; in_port = 4'hE;
        tick(5); rd_check(2'd0, 32'd0, "t2_data_edge4");
        tick(1); rd_check(2'd0, 32'd1, "t2_data_edge5");
        rd_check(2'd3, 32'd0, "t2_no_rise_capture");
        tick(3);
        in_port = 4'hF;
        tick(5); rd_check(2'd0, 32'd1, "t2_data_held");
        tick(1); rd_check(2'd0, 32'd0, "t2_data_released");
        rd_check(2'd3, 32'd0, "t2_cap_edge5");
        tick(1); rd_check(2'd3, 32'd1, "t2_cap_edge6");
        check("t2_irq_masked", {31'd0, irq}, 32'd0);

        // W1C, mask, ignored writes, irq assertion and clear.
        wr(2'd3, 32'd0); rd_check(2'd3, 32'd1, "t3_w1c_zero_noop");
        wr(2'd3, 32'd1); rd_check(2'd3, 32'd0, "t3_w1c_clear");
        wr(2'd1, 32'hFFFF_FFF1); rd_check(2'd1, 32'd1, "t3_mask_upper_ignored");
        wr(2'd0, 32'hFFFF_FFFF); rd_check(2'd0, 32'd0, "t3_data_ro");
        check("t3_irq_idle", {31'd0, irq}, 32'd0);
        in_port = 4'hE; tick(6);
        in_port = 4'hF; tick(6);
        check("t3_irq_before", {31'd0, irq}, 32'd0);
        tick(1);
        check("t3_irq_set", {31'd0, irq}, 32'd1);
        wr(2'd2, 32'hF); rd_check(2'd3, 32'd1, "t3_rsvd_write_no_clear");
        rd_check(2'd2, 32'd0, "t3_rsvd_read");
        wr(2'd3, 32'd1); rd_check(2'd3, 32'd0, "t3_cap_cleared");
        check("t3_irq_cleared", {31'd0, irq}, 32'd0);

        // Three-cycle glitch rejected; four-cycle pulse is the shortest accepted.
        address = 2'd0; in_port = 4'hD; tick(3);
        in_port = 4'hF; tick(8);
        rd_check(2'd0, 32'd0, "t4_glitch_data");
        rd_check(2'd3, 32'd0, "t4_glitch_cap");
        check("t4_glitch_irq", {31'd0, irq}, 32'd0);
        in_port = 4'hB; tick(4);
        in_port = 4'hF; tick(2);
        rd_check(2'd0, 32'd4, "t4_min_pulse_data");
        tick(5);
        rd_check(2'd0, 32'd0, "t4_min_pulse_gone");
        rd_check(2'd3, 32'd4, "t4_min_pulse_cap");
        check("t4_unmasked_no_irq", {31'd0, irq}, 32'd0);
        wr(2'd3, 32'd4); rd_check(2'd3, 32'd0, "t4_cap_cleared");

        // New capture on bit0 lands in the same cycle as its W1C.
        in_port = 4'hE; tick(6);
        in_port = 4'hF; tick(7);
        rd_check(2'd3, 32'd1, "t5_first_capture");
        in_port = 4'hE; tick(6);
        in_port = 4'hF; tick(6);
        wr(2'd3, 32'd1);
        rd_check(2'd3, 32'd1, "t5_set_beats_clear");
        check("t5_irq_held", {31'd0, irq}, 32'd1);
        wr(2'd3, 32'd1); rd_check(2'd3, 32'd0, "t5_cap_cleared");

        // Reset mid-debounce (count at 2) with KEY0 still held.
        address = 2'd0; in_port = 4'hE; tick(4);
        reset_n = 1'b0; tick(2);
        reset_n = 1'b1;
        tick(5); rd_check(2'd0, 32'd0, "t6_data_edge4");
        tick(1); rd_check(2'd0, 32'd1, "t6_data_edge5");
        rd_check(2'd3, 32'd0, "t6_no_capture");
        tick(1); rd_check(2'd1, 32'd0, "t6_mask_cleared");
        tick(8);
        rd_check(2'd3, 32'd0, "t6_no_late_capture");
        check("t6_irq", {31'd0, irq}, 32'd0);
        in_port = 4'hF; tick(8);
        rd_check(2'd3, 32'd1, "t6_release_capture");

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
